// File: rtl/led_tx_pkg.sv
// -----------------------------------------------------------------------------
// led_tx_pkg
// Shared definitions for the LED strip transmitter:
//   - FSM state encoding (IDLE, FETCH, SEND, LATCH, DONE)
//   - default WS2812 timing constants for a 50 MHz clock
//   - word size of one LED (24-bit GRB)
//   - small helper for counter widths
// -----------------------------------------------------------------------------
package led_tx_pkg;

  // One LED word is 24 bits of GRB colour.
  localparam int BITS_PER_LED = 24;

  // Default timing at 50 MHz: 1.25 us bit period, 0.4 us / 0.8 us high times,
  // 50 us latch gap.
  localparam int DEF_TBIT = 63;
  localparam int DEF_T0H  = 20;
  localparam int DEF_T1H  = 40;
  localparam int DEF_TRST = 2500;

  // FSM state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_LATCH = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Width of a counter that must hold values 0..n-1 (at least 1 bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_bit_encoder.sv
// -----------------------------------------------------------------------------
// led_bit_encoder
// Produces one WS2812-style bit period on the serial data line.
//
// Ports:
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   start     in   one-cycle pulse: begin a new bit period on the next cycle
//   bit_val   in   value of the bit to send, sampled with start
//   led_dout  out  serial data line (registered)
//   bit_done  out  high on the last cycle of the current bit period
//
// A period started in cycle c occupies cycles c+1 .. c+TBIT. Because bit_done
// marks cycle c+TBIT, the caller can raise start in that same cycle to get
// back-to-back periods with no idle cycle in between.
// -----------------------------------------------------------------------------
module led_bit_encoder
  import led_tx_pkg::*;
#(
  parameter int TBIT = DEF_TBIT,
  parameter int T0H  = DEF_T0H,
  parameter int T1H  = DEF_T1H
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic bit_val,
  output logic led_dout,
  output logic bit_done
);

  localparam int CW  = cnt_width(TBIT);
  localparam int CW1 = CW + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TBIT - 1);
  localparam logic [CW1-1:0] HIGH0 = CW1'(T0H);
  localparam logic [CW1-1:0] HIGH1 = CW1'(T1H);

  logic          active_reg;
  logic          one_reg;
  logic          dout_reg;
  logic [CW-1:0] cnt_reg;

  logic [CW1-1:0] cnt_next;
  logic [CW1-1:0] high_len;

  always_comb begin
    cnt_next = {1'b0, cnt_reg} + CW1'(1);
    high_len = one_reg ? HIGH1 : HIGH0;
  end

  assign bit_done = active_reg && (cnt_reg == CNT_LAST);
  assign led_dout = dout_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      active_reg <= 1'b0;
      one_reg    <= 1'b0;
      dout_reg   <= 1'b0;
      cnt_reg    <= '0;
    end else if (start) begin
      // Every bit begins with a high phase, so drive high straight away.
      active_reg <= 1'b1;
      one_reg    <= bit_val;
      dout_reg   <= 1'b1;
      cnt_reg    <= '0;
    end else if (active_reg) begin
      if (cnt_reg == CNT_LAST) begin
        active_reg <= 1'b0;
        dout_reg   <= 1'b0;
      end else begin
        cnt_reg  <= cnt_next[CW-1:0];
        // dout for the coming cycle: high while its count is below the high time.
        dout_reg <= (cnt_next < high_len);
      end
    end
  end

endmodule

// File: rtl/led_strip_tx.sv
// -----------------------------------------------------------------------------
// led_strip_tx
// Transmits one frame buffer to a WS2812-style LED strip on request.
//
// Ports:
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   led_tx         in   transmit request
//   led_tx_buf_id  in   buffer index, sampled when the request is accepted
//   led_tx_done    out  one-cycle pulse after the frame and latch gap
//   wbm_address    out  word address = buf_id*NLEDS + led_index (wrapping)
//   wbm_writedata  out  always 0
//   wbm_readdata   in   read data, bits 23:0 are GRB
//   wbm_strobe     out  Wishbone strobe (equal to wbm_cycle)
//   wbm_cycle      out  Wishbone cycle
//   wbm_write      out  always 0
//   wbm_ack        in   Wishbone acknowledge
//   led_dout       out  serial LED data line
//   busy           out  high from the cycle after acceptance through DONE
//
// The first word is fetched in FETCH. While a word is being shifted out the
// next one is read into a holding register, so a reasonably fast slave gives a
// gap-free bit stream. A late ack is used in the same cycle it arrives.
// -----------------------------------------------------------------------------
module led_strip_tx
  import led_tx_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NLEDS      = 8,
  parameter int TBIT       = DEF_TBIT,
  parameter int T0H        = DEF_T0H,
  parameter int T1H        = DEF_T1H,
  parameter int TRST       = DEF_TRST
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  led_tx,
  input  logic [DATA_WIDTH-1:0] led_tx_buf_id,
  output logic                  led_tx_done,
  output logic [ADDR_WIDTH-1:0] wbm_address,
  output logic [DATA_WIDTH-1:0] wbm_writedata,
  input  logic [DATA_WIDTH-1:0] wbm_readdata,
  output logic                  wbm_strobe,
  output logic                  wbm_cycle,
  output logic                  wbm_write,
  input  logic                  wbm_ack,
  output logic                  led_dout,
  output logic                  busy
);

  localparam int IDX_W  = cnt_width(NLEDS);
  localparam int LAT_W  = cnt_width(TRST);
  localparam int PROD_W = DATA_WIDTH + 32;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NLEDS - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(TRST - 1);
  localparam logic [4:0]       WORD_BITS = 5'(BITS_PER_LED);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [2:0]            state_reg;
  logic                  armed_reg;
  logic [ADDR_WIDTH-1:0] base_reg;        // buf_id*NLEDS, already wrapped
  logic [IDX_W-1:0]      idx_reg;         // LED word currently being sent
  logic [4:0]            bits_left_reg;   // bits of shift_reg not yet started
  logic [23:0]           shift_reg;
  logic [23:0]           next_word_reg;   // prefetched word idx_reg+1
  logic                  next_valid_reg;
  logic                  cyc_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [LAT_W-1:0]      latch_cnt_reg;
  logic                  inflight_reg;    // encoder is inside a bit period

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  logic              ack_now;
  logic              enc_free;
  logic              word_avail;
  logic              prefetch_go;
  logic              enc_start;
  logic              enc_bit;
  logic              bit_done;
  logic [23:0]       next_word_mux;
  logic [PROD_W-1:0] base_prod;

  // Product is formed wide and then truncated, which gives the required
  // modulo-2^ADDR_WIDTH wrap.
  assign base_prod = PROD_W'(led_tx_buf_id) * PROD_W'(NLEDS);

  always_comb begin
    ack_now       = cyc_reg && wbm_ack;
    enc_free      = !inflight_reg || bit_done;
    // A word arriving on the bus this very cycle counts as available.
    word_avail    = next_valid_reg || ack_now;
    next_word_mux = next_valid_reg ? next_word_reg : wbm_readdata[23:0];
    prefetch_go   = (state_reg == ST_SEND) && !cyc_reg && !next_valid_reg
                    && (idx_reg != LAST_IDX);

    enc_start = 1'b0;
    enc_bit   = 1'b0;
    if ((state_reg == ST_SEND) && enc_free) begin
      if (bits_left_reg != 5'd0) begin
        enc_start = 1'b1;
        enc_bit   = shift_reg[23];
      end else if ((idx_reg != LAST_IDX) && word_avail) begin
        enc_start = 1'b1;
        enc_bit   = next_word_mux[23];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM, bus master and counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      armed_reg      <= 1'b1;
      base_reg       <= '0;
      idx_reg        <= '0;
      bits_left_reg  <= '0;
      shift_reg      <= '0;
      next_word_reg  <= '0;
      next_valid_reg <= 1'b0;
      cyc_reg        <= 1'b0;
      addr_reg       <= '0;
      latch_cnt_reg  <= '0;
      inflight_reg   <= 1'b0;
    end else begin
      if (!led_tx) begin
        armed_reg <= 1'b1;
      end

      if (enc_start) begin
        inflight_reg <= 1'b1;
      end else if (bit_done) begin
        inflight_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (led_tx && armed_reg) begin
            armed_reg      <= 1'b0;
            base_reg       <= base_prod[ADDR_WIDTH-1:0];
            addr_reg       <= base_prod[ADDR_WIDTH-1:0];
            idx_reg        <= '0;
            next_valid_reg <= 1'b0;
            cyc_reg        <= 1'b1;
            state_reg      <= ST_FETCH;
          end
        end

        ST_FETCH: begin
          if (ack_now) begin
            shift_reg     <= wbm_readdata[23:0];
            bits_left_reg <= WORD_BITS;
            cyc_reg       <= 1'b0;
            state_reg     <= ST_SEND;
          end
        end

        ST_SEND: begin
          if (ack_now) begin
            cyc_reg        <= 1'b0;
            next_word_reg  <= wbm_readdata[23:0];
            next_valid_reg <= 1'b1;
          end

          if (prefetch_go) begin
            cyc_reg  <= 1'b1;
            addr_reg <= base_reg + ADDR_WIDTH'(idx_reg) + ADDR_WIDTH'(1);
          end

          if (enc_free) begin
            if (bits_left_reg != 5'd0) begin
              shift_reg     <= {shift_reg[22:0], 1'b0};
              bits_left_reg <= bits_left_reg - 5'd1;
            end else if (idx_reg == LAST_IDX) begin
              latch_cnt_reg <= '0;
              state_reg     <= ST_LATCH;
            end else if (word_avail) begin
              // Bit 23 of the new word starts this cycle; keep the rest.
              shift_reg      <= {next_word_mux[22:0], 1'b0};
              bits_left_reg  <= WORD_BITS - 5'd1;
              idx_reg        <= idx_reg + 1'b1;
              next_valid_reg <= 1'b0;
            end
          end
        end

        ST_LATCH: begin
          if (latch_cnt_reg == LAT_LAST) begin
            state_reg <= ST_DONE;
          end else begin
            latch_cnt_reg <= latch_cnt_reg + 1'b1;
          end
        end

        ST_DONE: begin
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Bit encoder
  // ---------------------------------------------------------------------------
  led_bit_encoder #(
    .TBIT (TBIT),
    .T0H  (T0H),
    .T1H  (T1H)
  ) u_encoder (
    .clk      (clk),
    .reset    (reset),
    .start    (enc_start),
    .bit_val  (enc_bit),
    .led_dout (led_dout),
    .bit_done (bit_done)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign wbm_cycle     = cyc_reg;
  assign wbm_strobe    = cyc_reg;
  assign wbm_address   = addr_reg;
  assign wbm_writedata = '0;
  assign wbm_write     = 1'b0;
  assign led_tx_done   = (state_reg == ST_DONE);
  assign busy          = (state_reg != ST_IDLE);

  // Upper read-data byte and high product bits are intentionally dropped.
  logic unused_bits;
  assign unused_bits = ^{wbm_readdata[DATA_WIDTH-1:24], base_prod[PROD_W-1:ADDR_WIDTH]};

endmodule

// File: tb/tb_led_strip_tx.sv
module tb_led_strip_tx;

  localparam int TBIT    = 63;
  localparam int T0H     = 20;
  localparam int T1H     = 40;
  localparam int TRST    = 2500;
  localparam int NA      = 2;
  localparam int NB      = 4;
  localparam int FRAME_T = NA * 24 * TBIT + TRST + 50;
  localparam int BUDGET  = FRAME_T + 3000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT A: 32-bit address, 2 LEDs ----------------
  logic        led_tx_a, done_a, stb_a, cyc_a, we_a, ack_a, dout_a, busy_a;
  logic [31:0] buf_a, addr_a, wdata_a, rdata_a;

  led_strip_tx #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .NLEDS(NA),
    .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRST(TRST)
  ) dut_a (
    .clk(clk), .reset(reset), .led_tx(led_tx_a), .led_tx_buf_id(buf_a),
    .led_tx_done(done_a), .wbm_address(addr_a), .wbm_writedata(wdata_a),
    .wbm_readdata(rdata_a), .wbm_strobe(stb_a), .wbm_cycle(cyc_a),
    .wbm_write(we_a), .wbm_ack(ack_a), .led_dout(dout_a), .busy(busy_a)
  );

  // ---------------- DUT B: 8-bit address, 4 LEDs ----------------
  logic        led_tx_b, done_b, stb_b, cyc_b, we_b, ack_b, dout_b, busy_b;
  logic [31:0] buf_b, wdata_b, rdata_b;
  logic [7:0]  addr_b;

  led_strip_tx #(
    .ADDR_WIDTH(8), .DATA_WIDTH(32), .NLEDS(NB),
    .TBIT(TBIT), .T0H(T0H), .T1H(T1H), .TRST(TRST)
  ) dut_b (
    .clk(clk), .reset(reset), .led_tx(led_tx_b), .led_tx_buf_id(buf_b),
    .led_tx_done(done_b), .wbm_address(addr_b), .wbm_writedata(wdata_b),
    .wbm_readdata(rdata_b), .wbm_strobe(stb_b), .wbm_cycle(cyc_b),
    .wbm_write(we_b), .wbm_ack(ack_b), .led_dout(dout_b), .busy(busy_b)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- slave / monitor state ----------------
  logic [31:0] mem_a [0:255];
  logic [31:0] slow_addr;
  int          max_delay;
  bit          wave_q[$];
  int          addr_q[$];
  int          ack_idx_q[$];
  int          done_idx_q[$];
  int          done_cnt_a, proto_err_a;
  int          wait_a, dly_a;
  logic [31:0] held_addr_a;
  logic [23:0] dec_q[$];
  int          dec_bits;
  int          frame_first;

  int          addr_q_b[$];
  int          done_cnt_b, wait_b, dly_b;

  // Slave for A: acks after a random (or forced slow) delay, records samples.
  initial begin : mon_a
    ack_a = 1'b0; rdata_a = '0; wait_a = 0; dly_a = 1;
    done_cnt_a = 0; proto_err_a = 0;
    forever begin
      @(negedge clk);
      wave_q.push_back(dout_a);
      if (done_a) begin
        done_cnt_a++;
        done_idx_q.push_back(wave_q.size() - 1);
      end
      if (cyc_a !== stb_a || we_a !== 1'b0 || wdata_a !== 32'd0) proto_err_a++;
      if (ack_a) begin
        ack_a = 1'b0; wait_a = 0; rdata_a = $urandom;
      end else if (cyc_a && stb_a) begin
        if (wait_a == 0) begin
          held_addr_a = addr_a;
          dly_a = (addr_a == slow_addr) ? 2000 : int'($urandom_range(max_delay, 1));
        end else if (addr_a !== held_addr_a) begin
          proto_err_a++;
        end
        wait_a++;
        if (wait_a >= dly_a) begin
          ack_a = 1'b1;
          rdata_a = mem_a[addr_a[7:0]];
          addr_q.push_back(int'(addr_a));
          ack_idx_q.push_back(wave_q.size() - 1);
        end
      end else begin
        wait_a = 0;
      end
    end
  end

  initial begin : mon_b
    ack_b = 1'b0; rdata_b = '0; wait_b = 0; dly_b = 1; done_cnt_b = 0;
    forever begin
      @(negedge clk);
      if (done_b) done_cnt_b++;
      if (ack_b) begin
        ack_b = 1'b0; wait_b = 0; rdata_b = $urandom;
      end else if (cyc_b && stb_b) begin
        if (wait_b == 0) dly_b = int'($urandom_range(5, 1));
        wait_b++;
        if (wait_b >= dly_b) begin
          ack_b = 1'b1; rdata_b = $urandom;
          addr_q_b.push_back(int'(addr_b));
        end
      end else begin
        wait_b = 0;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [31:0] id, input bit hold);
    wave_q.delete(); addr_q.delete(); ack_idx_q.delete(); done_idx_q.delete();
    done_cnt_a = 0;
    buf_a = id; led_tx_a = 1'b1;
    tick(1);
    if (!hold) led_tx_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag);
    int n = 0;
    while (done_cnt_a == 0 && n < BUDGET) begin tick(1); n++; end
    check({tag, "_done_seen"}, done_cnt_a != 0, 1'b1);
    check({tag, "_busy_after"}, {busy_a, done_a}, 2'b00);
  endtask

  function automatic int count_rises();
    int r = 0;
    for (int i = 0; i < wave_q.size(); i++)
      if (wave_q[i] && (i == 0 || !wave_q[i-1])) r++;
    return r;
  endfunction

  // Recover words from high-pulse lengths, independent of expected data.
  task automatic decode_wave();
    int run; logic [23:0] w;
    dec_q.delete(); dec_bits = 0; w = '0;
    for (int i = 0; i < wave_q.size(); i++) begin
      if (wave_q[i] && (i == 0 || !wave_q[i-1])) begin
        run = 0;
        while (i + run < wave_q.size() && wave_q[i + run]) run++;
        w = {w[22:0], run > (T0H + T1H) / 2};
        dec_bits++;
        if (dec_bits % 24 == 0) dec_q.push_back(w);
      end
    end
  endtask

  // Builds the ideal waveform from memory contents and slave ack times and
  // compares it sample by sample from the first rising edge.
  task automatic check_frame(input string tag, input logic [31:0] id);
    bit exp_q[$];
    int f, mism, start, hi;
    logic [31:0] a;
    logic [23:0] w;
    check({tag, "_nreads"}, addr_q.size(), NA);
    for (int j = 0; j < NA && j < addr_q.size(); j++) begin
      a = id * NA + j;
      check($sformatf("%s_addr%0d", tag, j), addr_q[j], a);
    end
    f = -1;
    for (int i = 0; i < wave_q.size(); i++) if (wave_q[i]) begin f = i; break; end
    check({tag, "_first_rise"}, f >= 0, 1'b1);
    if (f < 0) return;
    for (int j = 0; j < NA; j++) begin
      if (j > 0 && j < ack_idx_q.size()) begin
        start = ack_idx_q[j] + 1;
        while (f + exp_q.size() < start) exp_q.push_back(1'b0);
      end
      a = id * NA + j;
      w = mem_a[a[7:0]][23:0];
      for (int b = 23; b >= 0; b--) begin
        hi = w[b] ? T1H : T0H;
        for (int c = 0; c < TBIT; c++) exp_q.push_back(c < hi);
      end
    end
    repeat (TRST) exp_q.push_back(1'b0);
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (f + i >= wave_q.size() || wave_q[f + i] !== exp_q[i]) mism++;
    check({tag, "_wave_mismatches"}, mism, 0);
    check({tag, "_ndone"}, done_idx_q.size(), 1);
    check({tag, "_done_at"}, (done_idx_q.size() > 0) ? done_idx_q[0] : -1, f + exp_q.size());
    check({tag, "_protocol"}, proto_err_a, 0);
    decode_wave();
    check({tag, "_nbits"}, dec_bits, 24 * NA);
    frame_first = f;
  endtask

  // ---------------- directed sequence ----------------
  int          n;
  logic [31:0] id;

  initial begin : main
    reset = 1'b1; led_tx_a = 1'b0; buf_a = '0; led_tx_b = 1'b0; buf_b = '0;
    max_delay = 1; slow_addr = '1; frame_first = 0;
    for (int i = 0; i < 256; i++) mem_a[i] = $urandom;
    tick(3);
    check("reset_ctrl_a", {dout_a, cyc_a, stb_a, done_a, busy_a, we_a}, 6'd0);
    check("reset_addr_a", addr_a, 32'd0);
    check("reset_ctrl_b", {dout_b, cyc_b, stb_b, done_b, busy_b, we_b}, 6'd0);
    reset = 1'b0;
    tick(2);

    // Basic frame
    mem_a[6] = 32'h00A50F3C; mem_a[7] = 32'hFF000001; max_delay = 1;
    start_a(32'd3, 1'b0);
    wait_done_a("basic");
    check_frame("basic", 32'd3);
    check("basic_word0", (dec_q.size() > 0) ? dec_q[0] : 24'hx, 24'hA50F3C);
    check("basic_word1", (dec_q.size() > 1) ? dec_q[1] : 24'hx, 24'h000001);
    $display("basic frame: reads=%0d bits=%0d dones=%0d", addr_q.size(), dec_bits, done_cnt_a);

    // Slow slave on word 1
    max_delay = 20; id = $urandom_range(40, 1); slow_addr = id * NA + 1;
    start_a(id, 1'b0);
    wait_done_a("slow");
    check_frame("slow", id);
    check("slow_gap", (ack_idx_q.size() > 1) && (ack_idx_q[1] + 1 - frame_first > 24 * TBIT), 1'b1);
    slow_addr = '1;
    $display("slow frame: buf=%0d bits=%0d", id, dec_bits);

    // Held request: exactly one frame, then re-rise gives a second
    id = $urandom_range(100, 1);
    start_a(id, 1'b1);
    tick(3 * FRAME_T);
    check("held_one_done", done_cnt_a, 1);
    check("held_busy", busy_a, 1'b0);
    check_frame("held", id);
    led_tx_a = 1'b0;
    tick(1);
    id = $urandom_range(100, 1);
    start_a(id, 1'b0);
    wait_done_a("rerise");
    check_frame("rerise", id);
    $display("held request: second frame buf=%0d dones=%0d", id, done_cnt_a);

    // Reset during bit 10 of word 0
    id = $urandom_range(100, 1);
    start_a(id, 1'b0);
    n = 0;
    while (count_rises() < 11 && n < 3000) begin tick(1); n++; end
    check("rst_reach_bit10", count_rises() >= 11, 1'b1);
    reset = 1'b1;
    tick(1);
    check("rst_outputs", {dout_a, cyc_a, stb_a, busy_a, done_a}, 5'd0);
    reset = 1'b0;
    tick(100);
    check("rst_no_done", done_cnt_a, 0);
    id = $urandom_range(100, 1);
    start_a(id, 1'b0);
    wait_done_a("post_rst");
    check_frame("post_rst", id);
    $display("reset mid-frame: recovery frame buf=%0d bits=%0d", id, dec_bits);

    // Request while busy is ignored
    start_a(32'd3, 1'b0);
    tick(500);
    buf_a = 32'd5; led_tx_a = 1'b1;
    tick(1);
    led_tx_a = 1'b0;
    wait_done_a("busy_req");
    check_frame("busy_req", 32'd3);
    tick(200);
    check("busy_req_no_restart", {done_cnt_a, 31'd0, busy_a}, {32'd1, 31'd0, 1'b0});
    $display("request while busy: reads=%0d dones=%0d", addr_q.size(), done_cnt_a);

    // Address wrap on the 8-bit DUT
    buf_b = 32'd70; led_tx_b = 1'b1;
    tick(1);
    led_tx_b = 1'b0;
    n = 0;
    while (done_cnt_b == 0 && n < NB * 24 * TBIT + TRST + 500) begin tick(1); n++; end
    check("wrap_done", done_cnt_b, 1);
    check("wrap_nreads", addr_q_b.size(), NB);
    for (int j = 0; j < NB && j < addr_q_b.size(); j++)
      check($sformatf("wrap_addr%0d", j), addr_q_b[j], (70 * NB + j) % 256);
    check("wrap_busy_after", busy_b, 1'b0);
    $display("address wrap: reads=%0d dones=%0d", addr_q_b.size(), done_cnt_b);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_strip_tx.md
Name: led_strip_tx

Overview:
- Downstream consumer of ctrl_logic's LED transmit request (led_tx / led_tx_buf_id / led_tx_done).
- On request, reads one frame buffer out of buf_manager through a Wishbone master port, one 24-bit GRB word per LED.
- Serialises each word onto a single-wire WS2812-style data line, then drives the latch (reset) gap.
- Returns a one-cycle led_tx_done pulse to ctrl_logic.

Parameters:
- ADDR_WIDTH, 32, Wishbone address width.
- DATA_WIDTH, 32, Wishbone data width; also the width of the buf_id input.
- NLEDS, 8, LEDs per buffer (words per buffer, ≥1).
- TBIT, 63, clk cycles per bit period (1.25 us at 50 MHz).
- T0H, 20, high time for a '0' bit, in cycles (< T1H < TBIT).
- T1H, 40, high time for a '1' bit, in cycles.
- TRST, 2500, low latch time after the last bit, in cycles (50 us).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- led_tx  in  1  transmit request from ctrl_logic
- led_tx_buf_id  in  DATA_WIDTH  buffer index to transmit, sampled at start
- led_tx_done  out  1  one-cycle pulse when the frame and latch gap are complete
- wbm_address  out  ADDR_WIDTH  word address = buf_id*NLEDS + led_index
- wbm_writedata  out  DATA_WIDTH  tied to 0
- wbm_readdata  in  DATA_WIDTH  read data; bits 23:0 are GRB, bits 31:24 are ignored
- wbm_strobe  out  1  Wishbone strobe
- wbm_cycle  out  1  Wishbone cycle
- wbm_write  out  1  tied to 0 (read-only master)
- wbm_ack  in  1  Wishbone acknowledge
- led_dout  out  1  serial LED data line
- busy  out  1  high from accepted request until the done pulse

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: every output is 0; state = IDLE; armed = 1. Reset mid-frame aborts immediately: led_dout low, bus released the same edge, no done pulse.
- States:
  - IDLE: if led_tx && armed, latch buf_id, set led_index = 0, clear armed, go to FETCH.
  - FETCH: drive cyc = stb = 1, we = 0, address of word led_index. On the ack cycle, capture readdata[23:0] into the shift register, drop cyc/stb on the next edge, go to SEND.
  - SEND: transmit 24 bits, MSB (bit 23) first.
  - LATCH: hold led_dout low for TRST cycles, then go to DONE.
  - DONE: led_tx_done = 1 for exactly one cycle, then go to IDLE.
- Bit encoding: each bit lasts exactly TBIT cycles. led_dout is high for the first T1H cycles for a '1', or the first T0H cycles for a '0', and low for the remainder.
- Prefetch:
  - While word k is in SEND with k < NLEDS-1, the master issues the read for word k+1 into a holding register, so an ack arrives before the bit stream ends.
  - If word k+1 is valid when bit 0 of word k ends, the next bit starts on the following cycle: no gap, 24*NLEDS*TBIT contiguous cycles.
  - If word k+1 is not yet valid (slow ack), led_dout stays low until the ack. The first bit of word k+1 starts the cycle after the ack. No bits are dropped or repeated.
- After the last word's bit 0, go to LATCH.
- Bus rules:
  - cyc and stb are always equal.
  - Address and control are stable while stb is high and waiting for ack.
  - At most one outstanding read.
  - Bus is idle in IDLE, LATCH and DONE.
  - No timeout: a never-acked read hangs until reset.
- Address arithmetic: buf_id*NLEDS + led_index is computed in ADDR_WIDTH bits and wraps modulo 2^ADDR_WIDTH. led_index runs 0..NLEDS-1.
- busy is high from the cycle after acceptance through the DONE cycle.
- Re-arm: armed is set whenever led_tx is sampled low. A request held high across DONE does not start a second frame; led_tx must drop for at least 1 cycle first.
- led_tx and led_tx_buf_id changes while busy are ignored.

Decomposition:
- Shared package led_tx_pkg:
  - state encoding (IDLE, FETCH, SEND, LATCH, DONE);
  - default timing constants (TBIT, T0H, T1H, TRST) for 50 MHz;
  - BITS_PER_LED = 24.
- One sub-module, led_bit_encoder:
  - inputs: start pulse and bit value;
  - outputs: led_dout and a bit_done pulse on the last cycle of the TBIT period;
  - owns the period and high-time counter.
- The top holds the FSM, the Wishbone master, the prefetch register and the bit/LED counters.

Test Plan:
- Basic frame: NLEDS=2, buf_id=3, slave returns 0x00A50F3C (addr 6) and 0xFF000001 (addr 7), ack one cycle after stb. Required:
  - exactly two reads, at addresses 6 then 7;
  - 48 contiguous bit periods of 63 cycles;
  - decoded high times give 0xA50F3C then 0x000001 (top byte ignored);
  - then 2500 low cycles;
  - led_tx_done high for 1 cycle;
  - busy low the next cycle.
- Slow slave: ack for word 1 delayed 2000 cycles. Required:
  - led_dout low from the end of word 0 until the ack;
  - word 1 starts the cycle after the ack, still 24 correct bits;
  - total bits = 48.
- Held request: led_tx held high for 3 frame times. Required: exactly one frame and one done pulse; a second frame starts only after led_tx drops and re-rises.
- Reset mid-frame: assert reset during bit 10 of word 0. Required:
  - next cycle led_dout = 0, cyc = stb = 0, busy = 0;
  - no done pulse;
  - a new led_tx after reset transmits a full, correct frame.
- Address wrap: ADDR_WIDTH=8, NLEDS=4, buf_id=70. Required: reads at addresses 24, 25, 26, 27 (280 mod 256 = 24).
- Request while busy: pulse led_tx with buf_id=5 mid-frame. Required: ignored; the current frame's addresses are unchanged and only one done pulse occurs.
